display_scan_controller: RTL and testbench

- Time-multiplexes DIGITS 4-bit counter values onto one shared, common-anode 7-segment display bus.
- Sequences digit selects through a dwell/guard state machine and decodes one nibble at a time through a single shared decoder.
- Sits downstream of one or more digit counters; consumes their packed values and drives the board display pins.

---
 rtl/display_pkg.sv | 28 ++
 rtl/display_scan_controller_hex2seg.sv | 36 +++
 rtl/display_scan_controller.sv | 162 ++++++++++++++++
 tb/tb_display_scan_controller.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg
// Shared definitions for the multiplexed 7-segment display controller.
//   - state_t     : scan sequencer states (guard gap / digit shown)
//   - SEG_0..SEG_F: active-low {g,f,e,d,c,b,a} patterns for hex digits
//   - SEG_BLANK   : all segments off
package display_pkg;

  typedef enum logic {ST_GUARD, ST_SHOW} state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/display_scan_controller_hex2seg.sv
// hex2seg
// Combinational hex nibble to active-low 7-segment pattern decoder.
// One instance is shared by all digits of the scan controller.
// Ports:
//   nibble_i : 4-bit hex value
//   seg_o    : {g,f,e,d,c,b,a}, active-low
module hex2seg
  import display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
    endcase
  end

endmodule

// File: rtl/display_scan_controller.sv
// display_scan_controller
// Time-multiplexes DIGITS hex nibbles onto one common-anode 7-segment bus.
// Each digit is lit for DWELL_CYCLES, separated by GUARD_CYCLES with all
// anodes off to avoid ghosting. All outputs are registered.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   enable       : scan enable; low blanks the display and holds the digit index
//   values       : packed nibbles, digit i = values[4*i+3:4*i], digit 0 rightmost
//   dp_mask      : decimal point request per digit (1 = lit)
//   segments     : {g,f,e,d,c,b,a}, active-low
//   dp_n         : decimal point, active-low
//   anode_n      : digit select, active-low, one-cold or all-ones
//   frame_done   : one-cycle pulse in the first guard cycle after the last digit
// Build option:
//   DISPLAY_SCAN_CONTROLLER_BLANK_LEADING_EN : suppress leading zero digits
module display_scan_controller
  import display_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   values,
  input  logic [DIGITS-1:0]     dp_mask,
  output logic [6:0]            segments,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     anode_n,
  output logic                  frame_done
);

  localparam int MAX_CYC = (DWELL_CYCLES > GUARD_CYCLES) ? DWELL_CYCLES : GUARD_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IDX_W   = $clog2(DIGITS);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DIGITS-1:0]  anode_n_q, anode_n_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_n_q, dp_n_d;
  logic               frame_done_q, frame_done_d;

  logic [3:0]         nibble;
  logic [6:0]         decoded;
  logic               lightDigit;

  // The shared decoder always looks at the digit about to be shown; its
  // result is only captured on the guard-to-show transition.
  always_comb begin
    nibble = values[4*int'(idx_q) +: 4];
  end

  hex2seg u_hex2seg (
    .nibble_i (nibble),
    .seg_o    (decoded)
  );

`ifdef DISPLAY_SCAN_CONTROLLER_BLANK_LEADING_EN
  logic leadZero;

  // A digit is a leading zero when it and every more significant nibble
  // are zero. Digit 0 and digits with a requested decimal point stay lit.
  always_comb begin
    leadZero = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (j >= int'(idx_q) && values[4*j +: 4] != 4'h0) begin
        leadZero = 1'b0;
      end
    end
  end

  assign lightDigit = (idx_q == '0) || !leadZero || dp_mask[idx_q];
`else
  assign lightDigit = 1'b1;
`endif

  // Next-state and registered-output logic. Outputs are computed together
  // with the state change so they appear in the first cycle of the new state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    idx_d        = idx_q;
    anode_n_d    = anode_n_q;
    seg_d        = seg_q;
    dp_n_d       = dp_n_q;
    frame_done_d = 1'b0;

    if (!enable) begin
      state_d   = ST_GUARD;
      cnt_d     = '0;
      anode_n_d = '1;
      seg_d     = SEG_BLANK;
      dp_n_d    = 1'b1;
    end else begin
      case (state_q)
        ST_GUARD: begin
          anode_n_d = '1;
          seg_d     = SEG_BLANK;
          dp_n_d    = 1'b1;
          if (cnt_q == GUARD_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
            if (lightDigit) begin
              anode_n_d = ~(DIGITS'(1) << idx_q);
              seg_d     = decoded;
              dp_n_d    = ~dp_mask[idx_q];
            end
          end
        end
        ST_SHOW: begin
          if (cnt_q == DWELL_LAST) begin
            state_d      = ST_GUARD;
            cnt_d        = '0;
            idx_d        = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            anode_n_d    = '1;
            seg_d        = SEG_BLANK;
            dp_n_d       = 1'b1;
            frame_done_d = (idx_q == IDX_LAST);
          end
        end
        default: begin
          state_d = ST_GUARD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_GUARD;
      cnt_q        <= '0;
      idx_q        <= '0;
      anode_n_q    <= '1;
      seg_q        <= SEG_BLANK;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      anode_n_q    <= anode_n_d;
      seg_q        <= seg_d;
      dp_n_q       <= dp_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign anode_n    = anode_n_q;
  assign segments   = seg_q;
  assign dp_n       = dp_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller
// Scoreboard bench for display_scan_controller with DIGITS=4, DWELL_CYCLES=4,
// GUARD_CYCLES=2. Expected per-cycle outputs are queued when a scenario is set
// up; a monitor on the falling edge pops one entry per cycle and compares.
// Honours DISPLAY_SCAN_CONTROLLER_BLANK_LEADING_EN for the leading-zero case.
module tb_display_scan_controller;

  localparam int DIGITS = 4;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] SF = 7'b0001110;
  localparam logic [6:0] SOFF = 7'b1111111;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b1;
  logic [15:0]       values = 16'h0000;
  logic [3:0]        dpMask = 4'h0;
  logic [6:0]        segments;
  logic              dpN;
  logic [3:0]        anodeN;
  logic              frameDone;

  typedef struct {
    int         cyc;
    int         scen;
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    bit         segChk;
  } exp_t;

  exp_t expQ[$];
  exp_t cur;
  int   expCycle = 0;
  int   scen = 0;
  int   checks = 0;
  int   failures = 0;

  display_scan_controller #(
    .DIGITS       (DIGITS),
    .DWELL_CYCLES (4),
    .GUARD_CYCLES (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .values     (values),
    .dp_mask    (dpMask),
    .segments   (segments),
    .dp_n       (dpN),
    .anode_n    (anodeN),
    .frame_done (frameDone)
  );

  always #5 clock = ~clock;

  // Compare one queued expectation against the live outputs.
  task automatic checkOutput(input exp_t e);
    checks++;
    if (anodeN !== e.anode) begin
      failures++;
      $display("[TB] FAIL anode_n scen%0d cyc%0d: got %b want %b", e.scen, e.cyc, anodeN, e.anode);
    end
    checks++;
    if (frameDone !== e.fd) begin
      failures++;
      $display("[TB] FAIL frame_done scen%0d cyc%0d: got %b want %b", e.scen, e.cyc, frameDone, e.fd);
    end
    if (e.segChk) begin
      checks++;
      if (segments !== e.seg) begin
        failures++;
        $display("[TB] FAIL segments scen%0d cyc%0d: got %b want %b", e.scen, e.cyc, segments, e.seg);
      end
      checks++;
      if (dpN !== e.dp) begin
        failures++;
        $display("[TB] FAIL dp_n scen%0d cyc%0d: got %b want %b", e.scen, e.cyc, dpN, e.dp);
      end
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clock) begin
    if (expQ.size() > 0) begin
      cur = expQ.pop_front();
      checkOutput(cur);
    end
  end

  task automatic pushExp(input logic [3:0] an, input logic [6:0] sg, input logic dp,
                         input logic fd, input bit chk, input int n);
    for (int i = 0; i < n; i++) begin
      expQ.push_back('{cyc: expCycle, scen: scen, anode: an, seg: sg, dp: dp,
                       fd: (i == 0) ? fd : 1'b0, segChk: chk});
      expCycle++;
    end
  endtask

  task automatic pushOff(input int n);
    pushExp(4'hF, SOFF, 1'b1, 1'b0, 1'b1, n);
  endtask

  task automatic pushGuard(input int n, input logic fdFirst);
    pushExp(4'hF, SOFF, 1'b1, fdFirst, 1'b0, n);
  endtask

  task automatic pushShow(input logic [3:0] an, input logic [6:0] sg, input logic dp, input int n);
    pushExp(an, sg, dp, 1'b0, 1'b1, n);
  endtask

  // One 24-cycle frame; the first frame after reset starts with the reset cycle.
  task automatic pushFrame(input bit first, input logic fd, input logic [6:0] s0,
                           input logic [6:0] s1, input logic [6:0] s2,
                           input logic [6:0] s3, input logic [3:0] dpExp);
    if (first) begin
      pushOff(1);
      pushGuard(1, 1'b0);
    end else begin
      pushGuard(2, fd);
    end
    pushShow(4'b1110, s0, dpExp[0], 4);
    pushGuard(2, 1'b0);
    pushShow(4'b1101, s1, dpExp[1], 4);
    pushGuard(2, 1'b0);
    pushShow(4'b1011, s2, dpExp[2], 4);
    pushGuard(2, 1'b0);
    pushShow(4'b0111, s3, dpExp[3], 4);
  endtask

  // Drive one cycle's inputs and move to just after the next rising edge.
  task automatic applyStimulus(input logic rst, input logic en, input logic [15:0] v,
                               input logic [3:0] dm);
    reset  = rst;
    enable = en;
    values = v;
    dpMask = dm;
    @(posedge clock);
    #1;
  endtask

  task automatic doReset(input int s, input logic [15:0] v, input logic [3:0] dm);
    scen     = s;
    expCycle = 0;
    applyStimulus(1'b1, 1'b1, v, dm);
    applyStimulus(1'b1, 1'b1, v, dm);
    reset = 1'b0;
  endtask

  task automatic checkDrained();
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drained scen%0d: got %0d pending want 0", scen, expQ.size());
      expQ.delete();
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Scenario 1: basic scan, then a mid-dwell value change on digit 0.
    doReset(1, 16'h1234, 4'h0);
    pushFrame(1'b1, 1'b0, S4, S3, S2, S1, 4'hF);
    pushFrame(1'b0, 1'b1, S4, S3, S2, S1, 4'hF);
    pushGuard(2, 1'b1);
    pushShow(4'b1110, SF, 1'b1, 4);
    for (int c = 0; c < 54; c++) begin
      applyStimulus(1'b0, 1'b1, (c >= 27) ? 16'h123F : 16'h1234, 4'h0);
    end
    checkDrained();

    // Scenario 2: decimal point on digit 2 only.
    doReset(2, 16'h1234, 4'b0100);
    pushFrame(1'b1, 1'b0, S4, S3, S2, S1, 4'b1011);
    pushGuard(1, 1'b1);
    for (int c = 0; c < 25; c++) applyStimulus(1'b0, 1'b1, 16'h1234, 4'b0100);
    checkDrained();

    // Scenario 3: enable low during digit 0, back high at cycle 10.
    doReset(3, 16'h1234, 4'h0);
    pushOff(1);
    pushGuard(1, 1'b0);
    pushShow(4'b1110, S4, 1'b1, 2);
    pushOff(6);
    pushGuard(2, 1'b0);
    pushShow(4'b1110, S4, 1'b1, 4);
    pushGuard(2, 1'b0);
    pushShow(4'b1101, S3, 1'b1, 4);
    for (int c = 0; c < 22; c++) begin
      applyStimulus(1'b0, !(c >= 3 && c < 10), 16'h1234, 4'h0);
    end
    checkDrained();

    // Scenario 4: one-cycle reset in the middle of digit 1.
    doReset(4, 16'h1234, 4'h0);
    pushOff(1);
    pushGuard(1, 1'b0);
    pushShow(4'b1110, S4, 1'b1, 4);
    pushGuard(2, 1'b0);
    pushShow(4'b1101, S3, 1'b1, 1);
    pushOff(1);
    pushGuard(1, 1'b0);
    pushShow(4'b1110, S4, 1'b1, 4);
    pushGuard(2, 1'b0);
    pushShow(4'b1101, S3, 1'b1, 4);
    for (int c = 0; c < 21; c++) applyStimulus(c == 8, 1'b1, 16'h1234, 4'h0);
    checkDrained();

    // Scenario 5: leading zeros in 16'h0050.
    doReset(5, 16'h0050, 4'h0);
`ifdef DISPLAY_SCAN_CONTROLLER_BLANK_LEADING_EN
    pushOff(1);
    pushGuard(1, 1'b0);
    pushShow(4'b1110, S0, 1'b1, 4);
    pushGuard(2, 1'b0);
    pushShow(4'b1101, S5, 1'b1, 4);
    pushGuard(2, 1'b0);
    pushExp(4'hF, SOFF, 1'b1, 1'b0, 1'b0, 4);
    pushGuard(2, 1'b0);
    pushExp(4'hF, SOFF, 1'b1, 1'b0, 1'b0, 4);
    pushGuard(1, 1'b1);
`else
    pushFrame(1'b1, 1'b0, S0, S5, S0, S0, 4'hF);
    pushGuard(1, 1'b1);
`endif
    for (int c = 0; c < 25; c++) applyStimulus(1'b0, 1'b1, 16'h0050, 4'h0);
    checkDrained();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
